// File: rtl/sram_burst_responder_if.sv
// Requester-side bus of the SRAM burst responder.
// Signals: req/we/addr/wdata/burst_len (request, requester -> responder),
//          ready/ack/rdata/burst_rdata/burst_data_valid (responder -> requester).
// Modports: slave = responder view, master = requester view.
interface sram_burst_responder_if;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [7:0]  burst_len;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic [15:0] burst_rdata;
  logic        burst_data_valid;

  modport slave (
    input  req, we, addr, wdata, burst_len,
    output ready, ack, rdata, burst_rdata, burst_data_valid
  );

  modport master (
    output req, we, addr, wdata, burst_len,
    input  ready, ack, rdata, burst_rdata, burst_data_valid
  );
endinterface

// File: rtl/sram_burst_responder.sv
// SRAM burst responder: accepts a single 32-bit read/write or an N-word 16-bit
// read burst from a requester and executes it on a 16-bit pipelined memory port.
// Ports:
//   clk_sram, rst_n_sram      - clock, asynchronous active-low reset
//   bus (slave modport)       - requester handshake, request fields and read results
//   mem_cs/mem_we/mem_addr/mem_wdata (out), mem_rdata (in) - 16-bit memory port
// Read data returns READ_LATENCY cycles after issue; every output is registered.
module sram_burst_responder #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clk_sram,
  input  logic                   rst_n_sram,
  sram_burst_responder_if.slave  bus,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [23:0]            mem_addr,
  output logic [15:0]            mem_wdata,
  input  logic [15:0]            mem_rdata
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 16;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_ACK,
    ST_TURN
  } state_e;

  state_e                  state_q;
  logic                    we_q;
  logic                    single_q;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           issue_cnt_q;
  logic [LW-1:0]           ret_cnt_q;
  logic [MW-1:0]           wdata_hi_q;
  logic [MW-1:0]           rdata_lo_q;
  logic [READ_LATENCY-1:0] vld_q;

  logic                    ready_q;
  logic                    ack_q;
  logic [DW-1:0]           rdata_q;
  logic [MW-1:0]           burst_rdata_q;
  logic                    bdv_q;
  logic                    mem_cs_q;
  logic                    mem_we_q;
  logic [AW-1:0]           mem_addr_q;
  logic [MW-1:0]           mem_wdata_q;

  assign bus.ready            = ready_q;
  assign bus.ack              = ack_q;
  assign bus.rdata            = rdata_q;
  assign bus.burst_rdata      = burst_rdata_q;
  assign bus.burst_data_valid = bdv_q;
  assign mem_cs               = mem_cs_q;
  assign mem_we               = mem_we_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wdata            = mem_wdata_q;

  // Control FSM, in-flight read tracking and read-data capture.
  always_ff @(posedge clk_sram or negedge rst_n_sram) begin
    if (!rst_n_sram) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      single_q      <= 1'b0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      wdata_hi_q    <= '0;
      rdata_lo_q    <= '0;
      vld_q         <= '0;
      ready_q       <= 1'b1;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      burst_rdata_q <= '0;
      bdv_q         <= 1'b0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      bdv_q <= 1'b0;

      // One valid bit per read issued this cycle, aged READ_LATENCY stages.
      vld_q[0] <= (state_q == ST_ISSUE) && !we_q;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end

      // Oldest stage valid: mem_rdata holds the word for that issue now.
      if (vld_q[READ_LATENCY-1]) begin
        ret_cnt_q <= ret_cnt_q + LW'(1);
        if (single_q) begin
          if (ret_cnt_q == '0) rdata_lo_q <= mem_rdata;
          else                 rdata_q    <= {mem_rdata, rdata_lo_q};
        end else begin
          burst_rdata_q <= mem_rdata;
          bdv_q         <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            state_q     <= ST_ISSUE;
            ready_q     <= 1'b0;
            we_q        <= bus.we;
            single_q    <= !bus.we && (bus.burst_len == '0);
            // Writes and zero-length requests are two 16-bit words.
            len_q       <= (bus.we || bus.burst_len == '0) ? LW'(2) : bus.burst_len;
            wdata_hi_q  <= bus.wdata[31:16];
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mem_cs_q    <= 1'b1;
            mem_we_q    <= bus.we;
            mem_addr_q  <= bus.addr;
            if (bus.we) mem_wdata_q <= bus.wdata[15:0];
          end
        end

        ST_ISSUE: begin
          if (issue_cnt_q == len_q - LW'(1)) begin
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (we_q) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            issue_cnt_q <= issue_cnt_q + LW'(1);
            mem_addr_q  <= mem_addr_q + AW'(1);
            if (we_q) mem_wdata_q <= wdata_hi_q;
          end
        end

        // Wait until every issued word has been captured.
        ST_DRAIN: begin
          if (ret_cnt_q == len_q) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end

        ST_ACK: begin
          state_q <= ST_TURN;
        end

        // One dead cycle so a registered req drop is not seen as a new request.
        ST_TURN: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_responder.sv
// Self-checking bench for sram_burst_responder: a latency-accurate memory model,
// scoreboard queues of expected memory accesses and beats, and directed steps.
module tb_sram_burst_responder;

  localparam int RL = 2;

  typedef struct {
    int          cyc;
    logic [23:0] addr;
    logic        we;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        mem_cs;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  sram_burst_responder_if bus();

  sram_burst_responder #(.READ_LATENCY(RL)) dut (
    .clk_sram   (clk),
    .rst_n_sram (rst_n),
    .bus        (bus),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  int n_vec;
  int n_err;
  int cyc;
  int t0;
  bit mon_en;
  int exp_ack;
  bit exp_single;
  logic [31:0] exp_rdata;
  int ack_cnt;
  int bdv_cnt;
  int cs_cnt;

  acc_t  acc_q[$];
  beat_t beat_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: two fixed words, everything else derived from the address.
  function automatic logic [15:0] mem_f(input logic [23:0] a);
    if (a == 24'h000020) return 16'h1234;
    if (a == 24'h000021) return 16'hABCD;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Address issued in cycle T reaches stage RL-1 in cycle T+RL.
  logic [23:0] a_pipe [RL];
  always @(posedge clk) begin
    a_pipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign mem_rdata = mem_f(a_pipe[RL-1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ack) ack_cnt++;
    if (bus.burst_data_valid) bdv_cnt++;
    if (mem_cs) cs_cnt++;
  end

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    int    rel;
    acc_t  e;
    beat_t b;
    if (mon_en) begin
      rel = cyc - t0;
      if (rel == 1) check("ready_busy", 32'(bus.ready), 32'd0);
      if (mem_cs) begin
        if (acc_q.size() == 0) check("spurious_mem_cs", 32'(rel), 32'hFFFF_FFFF);
        else begin
          e = acc_q.pop_front();
          check("acc_cycle", 32'(rel), 32'(e.cyc));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end else if (mem_we) begin
        check("mem_we_without_cs", 32'(mem_we), 32'd0);
      end
      if (bus.burst_data_valid) begin
        if (beat_q.size() == 0) check("spurious_beat", 32'(rel), 32'hFFFF_FFFF);
        else begin
          b = beat_q.pop_front();
          check("beat_cycle", 32'(rel), 32'(b.cyc));
          check("burst_rdata", 32'(bus.burst_rdata), 32'(b.data));
        end
      end
      if (bus.ack) begin
        check("ack_cycle", 32'(rel), 32'(exp_ack));
        if (exp_single) check("rdata", bus.rdata, exp_rdata);
      end
    end
  end

  task automatic run_txn(input logic we, input logic [23:0] a, input logic [31:0] wd,
                         input logic [7:0] bl, input bit hold, input string tag);
    int L;
    bit got;
    L = (we || bl == 8'd0) ? 2 : int'(bl);
    for (int k = 0; k < L; k++)
      acc_q.push_back('{cyc: 1 + k, addr: a + 24'(k), we: we,
                        wdata: (k == 0) ? wd[15:0] : wd[31:16]});
    if (!we && bl != 8'd0)
      for (int k = 0; k < L; k++)
        beat_q.push_back('{cyc: k + RL + 2, data: mem_f(a + 24'(k))});
    exp_ack    = we ? L + 1 : L + RL + 2;
    exp_single = !we && bl == 8'd0;
    exp_rdata  = {mem_f(a + 24'd1), mem_f(a)};

    @(negedge clk);
    t0 = cyc;
    bus.req = 1'b1; bus.we = we; bus.addr = a; bus.wdata = wd; bus.burst_len = bl;
    mon_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (bus.ack) got = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (!hold) bus.req = 1'b0;
    @(negedge clk);
    check({tag, "_ready_turn"}, 32'(bus.ready), 32'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_acc_left"}, 32'(acc_q.size()), 32'd0);
    check({tag, "_beat_left"}, 32'(beat_q.size()), 32'd0);
    mon_en = 1'b0;
    acc_q.delete();
    beat_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check({tag, "_bdv"}, 32'(bus.burst_data_valid), 32'd0);
    check({tag, "_mem_cs"}, 32'(mem_cs), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_burst_rdata"}, 32'(bus.burst_rdata), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int ack0, bdv0, cs0;
    clk = 1'b0; rst_n = 1'b0; cyc = 0; t0 = 0; mon_en = 1'b0;
    n_vec = 0; n_err = 0; ack_cnt = 0; bdv_cnt = 0; cs_cnt = 0;
    exp_ack = -1; exp_single = 1'b0; exp_rdata = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.burst_len = '0;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: two halves, low half first.
    run_txn(1'b1, 24'h000010, 32'hDEADBEEF, 8'd0, 1'b0, "wr_single");
    // Single read assembling {addr+1, addr}.
    run_txn(1'b0, 24'h000020, 32'h0, 8'd0, 1'b0, "rd_single");
    // Long burst: issue cycles 1..128, beats 4..131, ack 132.
    run_txn(1'b0, 24'h000100, 32'h0, 8'd128, 1'b0, "rd_burst128");
    // Address wrap across the top of the 24-bit space.
    run_txn(1'b0, 24'hFFFFFE, 32'h0, 8'd4, 1'b0, "rd_wrap");
    check("rdata_held", bus.rdata, 32'hABCD1234);
    // Write ignores burst_len; req held through the turnaround cycle.
    run_txn(1'b1, 24'h000400, 32'hCAFE0123, 8'd7, 1'b1, "wr_len7_hold");
    // Odd burst length.
    run_txn(1'b0, 24'h000345, 32'h0, 8'd3, 1'b0, "rd_burst3");

    // Reset in cycle 50 of a 128-word burst.
    @(negedge clk);
    t0 = cyc;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h000100; bus.burst_len = 8'd128;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    ack0 = ack_cnt; bdv0 = bdv_cnt; cs0 = cs_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_beats", 32'(bdv_cnt - bdv0), 32'd0);
    check("post_reset_acks", 32'(ack_cnt - ack0), 32'd0);
    check("post_reset_mem_cs", 32'(cs_cnt - cs0), 32'd0);
    check("post_reset_ready", 32'(bus.ready), 32'd1);

    // Normal operation after the abort.
    run_txn(1'b0, 24'h000021, 32'h0, 8'd0, 1'b0, "rd_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_burst_responder.md
SRAM_BURST_RESPONDER -- requirements
Module: sram_burst_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning the number of cycles from a mem read issue to valid mem_rdata (legal 1..4).
REQ-002 SHALL have port clk_sram  input  1  core clock (100 MHz); the only clock.
REQ-003 SHALL have port rst_n_sram  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  request, held by the requester until ack.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 SHALL have port addr  input  24  16-bit-word start address.
REQ-007 SHALL have port wdata  input  32  single-word write data.
REQ-008 SHALL have port burst_len  input  8  0 = single 32-bit access; N = N-word 16-bit read burst.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  single-read result.
REQ-012 SHALL have port burst_rdata  output  16  burst beat data.
REQ-013 SHALL have port burst_data_valid  output  1  one pulse per burst beat.
REQ-014 SHALL have ports mem_cs (output, 1), mem_we (output, 1), mem_addr (output, 24), mem_wdata (output, 16) and mem_rdata (input, 16), forming the 16-bit memory port.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, ACK and TURN.
REQ-016 In IDLE, when req=1 is sampled, SHALL latch addr, we, wdata and burst_len, and SHALL enter ISSUE on the next cycle. This is cycle 1, counting the sampling cycle as cycle 0.
REQ-017 The access word count L SHALL be:
  - 2 when burst_len=0 or we=1; burst_len is ignored for writes, and writes are always single;
  - burst_len otherwise. Odd values are legal.
REQ-018 ISSUE SHALL drive exactly one mem access per cycle for L consecutive cycles:
  - mem_cs=1;
  - mem_addr = latched addr + k, for k = 0..L-1, mod 2^24; wraps 0xFFFFFF to 0x000000.
REQ-019 A write SHALL drive mem_we=1:
  - mem_wdata = wdata[15:0] at k=0;
  - mem_wdata = wdata[31:16] at k=1.
REQ-020 A read issued in cycle T SHALL sample mem_rdata at the end of cycle T+READ_LATENCY. In-flight reads SHALL be tracked with a READ_LATENCY-deep valid pipeline.
REQ-021 A burst read SHALL register each returned word so that burst_rdata is valid with burst_data_valid=1 for exactly one cycle, T+READ_LATENCY+1, in address order.
REQ-022 A single read SHALL assemble the result as rdata = {word at addr+1, word at addr}, with burst_data_valid held at 0.
REQ-023 After the last issue, SHALL go:
  - reads: to DRAIN, which waits until all L words have returned, then goes to ACK;
  - writes: directly to ACK.
REQ-024 ACK SHALL assert ack=1 for exactly one cycle, then go to TURN. For reads, ack SHALL fall in the cycle after the last burst_data_valid (burst) or the last rdata update (single). rdata SHALL hold its value until the next single-read completion.
REQ-025 TURN SHALL last one cycle with ready=0, ignore req, then return to IDLE. This absorbs the requester's registered req deassertion.
REQ-026 Outside ISSUE:
  - mem_cs=0 and mem_we=0;
  - mem_addr and mem_wdata hold their last values;
  - req changes after acceptance SHALL be ignored until IDLE.
REQ-027 ready SHALL be 1 only in IDLE. No new request SHALL be accepted while any read is in flight.

Reset
REQ-028 Reset assertion at any time, including mid-burst, SHALL:
  - force state IDLE;
  - clear the in-flight pipeline;
  - drop pending reads without emitting any beat.
REQ-029 Reset values SHALL be:
  - ready=1;
  - ack=0, burst_data_valid=0, mem_cs=0, mem_we=0;
  - rdata, burst_rdata, mem_addr and mem_wdata all zero.

Verification
REQ-030 Burst read, READ_LATENCY=2, addr=0x000100, burst_len=128, req sampled in cycle 0 -> mem_cs in cycles 1..128, addresses 0x100..0x17F; burst_data_valid in cycles 4..131 with data in order; ack in cycle 132; ready=1 from cycle 134.
REQ-031 Single write, addr=0x000010, wdata=0xDEADBEEF -> cycle 1: mem_addr 0x10, mem_wdata 0xBEEF; cycle 2: mem_addr 0x11, mem_wdata 0xDEAD; ack in cycle 3; no burst_data_valid.
REQ-032 Single read of memory holding 0x1234 at 0x20 and 0xABCD at 0x21 -> rdata=0xABCD1234 during the ack cycle; zero burst_data_valid pulses.
REQ-033 Wrap-around: addr=0xFFFFFE, burst_len=4 -> mem_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; exactly 4 beats.
REQ-034 Requester holding req high through ack plus one cycle, and a write with burst_len=7 -> no second acceptance occurs during TURN; the write performs exactly 2 mem accesses.
REQ-035 Reset asserted in cycle 50 of a 128-word burst -> outputs at reset values immediately; no beats or ack after release; ready=1.
